// File: rtl/vga_pkg.sv
// Shared screen geometry, palette codes and writer FSM states
// for the VGA frame-buffer write and scan-out paths.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL,
    DONE
  } wr_state_e;

  localparam logic [2:0] WHITE          = 3'd0;
  localparam logic [2:0] BLUE           = 3'd1;
  localparam logic [2:0] LIGHT_BLUE_213 = 3'd2;
  localparam logic [2:0] LIGHT_BLUE_170 = 3'd3;
  localparam logic [2:0] CYAN_127       = 3'd4;
  localparam logic [2:0] BLUE_84        = 3'd5;
  localparam logic [2:0] BLUE_43        = 3'd6;
  localparam logic [2:0] BLACK          = 3'd7;

  // lo selects the 160x120 geometry, otherwise 320x240
  function automatic int screen_w(bit lo);
    return lo ? 160 : 320;
  endfunction

  function automatic int screen_h(bit lo);
    return lo ? 120 : 240;
  endfunction

  function automatic int x_w(bit lo);
    return lo ? 8 : 9;
  endfunction

  function automatic int y_w(bit lo);
    return lo ? 7 : 8;
  endfunction

  function automatic int a_w(bit lo);
    return lo ? 15 : 17;
  endfunction

endpackage

// File: rtl/vga_xy_to_address.sv
// Pixel (x, y) to linear video RAM address, y*SCREEN_W + x,
// built from shifts and adds only so scan-out can share it.
module vga_xy_to_address #(
  parameter bit LO  = 1'b0,
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int A_W = 17
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic [A_W-1:0] address
);

  logic [A_W-1:0] xa;
  logic [A_W-1:0] ya;

  assign xa = A_W'(x);
  assign ya = A_W'(y);

  // 160 = 128 + 32, 320 = 256 + 64
  assign address = LO ? (ya << 7) + (ya << 5) + xa
                      : (ya << 8) + (ya << 6) + xa;

endmodule

// File: rtl/vga_rect_writer.sv
// Frame-buffer writer: clips rectangle / clear commands to the
// screen and streams one video RAM write per vga_clock.
module vga_rect_writer
  import vga_pkg::*;
#(
  parameter RESOLUTION = "320x240",
  parameter int COLOUR_BITS = 3,
  localparam bit LO = (RESOLUTION == "160x120"),
  localparam int SCREEN_W = screen_w(LO),
  localparam int SCREEN_H = screen_h(LO),
  localparam int X_W = x_w(LO),
  localparam int Y_W = y_w(LO),
  localparam int A_W = a_w(LO)
) (
  input  logic                   vga_clock,
  input  logic                   resetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_clear,
  input  logic [X_W-1:0]         cmd_x,
  input  logic [Y_W-1:0]         cmd_y,
  input  logic [X_W-1:0]         cmd_w,
  input  logic [Y_W-1:0]         cmd_h,
  input  logic [COLOUR_BITS-1:0] cmd_colour,
  output logic                   wr_en,
  output logic [A_W-1:0]         wr_address,
  output logic [COLOUR_BITS-1:0] wr_colour,
  output logic                   busy,
  output logic                   done
);

  localparam logic [X_W:0] SW = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SH = (Y_W+1)'(SCREEN_H);

  wr_state_e state_q, state_d;

  logic                   cmd_ready_q, cmd_ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   wr_en_q, wr_en_d;
  logic [A_W-1:0]         addr_q, addr_d;
  logic [COLOUR_BITS-1:0] colour_q, colour_d;

  logic                   clr_q, clr_d;
  logic [X_W-1:0]         x0_q, x0_d;
  logic [Y_W-1:0]         y0_q, y0_d;
  logic [X_W-1:0]         w_q, w_d;
  logic [Y_W-1:0]         h_q, h_d;
  logic [COLOUR_BITS-1:0] col_q, col_d;
  logic [X_W:0]           xe_q, xe_d;
  logic [Y_W:0]           ye_q, ye_d;
  logic [X_W-1:0]         xc_q, xc_d;
  logic [Y_W-1:0]         yc_q, yc_d;

  logic [X_W:0]   x_sum;
  logic [Y_W:0]   y_sum;
  logic           empty;
  logic           x_last;
  logic           y_last;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;
  logic [A_W-1:0] n_addr;

  assign x_sum = {1'b0, x0_q} + {1'b0, w_q};
  assign y_sum = {1'b0, y0_q} + {1'b0, h_q};

  assign empty = !clr_q &&
                 (w_q == '0 || h_q == '0 ||
                  {1'b0, x0_q} >= SW ||
                  {1'b0, y0_q} >= SH);

  assign x_last = ({1'b0, xc_q} == xe_q - (X_W+1)'(1));
  assign y_last = ({1'b0, yc_q} == ye_q - (Y_W+1)'(1));

  // Coordinates of the pixel written in the next cycle
  always_comb begin
    nx = xc_q;
    ny = yc_q;
    unique case (state_q)
      SETUP: begin
        nx = clr_q ? '0 : x0_q;
        ny = clr_q ? '0 : y0_q;
      end
      FILL: begin
        if (x_last) begin
          nx = x0_q;
          ny = yc_q + Y_W'(1);
        end else begin
          nx = xc_q + X_W'(1);
        end
      end
      default: ;
    endcase
  end

  vga_xy_to_address #(
    .LO  (LO),
    .X_W (X_W),
    .Y_W (Y_W),
    .A_W (A_W)
  ) u_xy (
    .x       (nx),
    .y       (ny),
    .address (n_addr)
  );

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    colour_d = colour_q;
    clr_d    = clr_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    col_d    = col_q;
    xe_d     = xe_q;
    ye_d     = ye_q;
    xc_d     = xc_q;
    yc_d     = yc_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          clr_d   = cmd_clear;
          x0_d    = cmd_x;
          y0_d    = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          col_d   = cmd_colour;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (clr_q) begin
          x0_d = '0;
          y0_d = '0;
          xe_d = SW;
          ye_d = SH;
        end else begin
          xe_d = (x_sum > SW) ? SW : x_sum;
          ye_d = (y_sum > SH) ? SH : y_sum;
        end
        if (empty) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d  = FILL;
          xc_d     = nx;
          yc_d     = ny;
          wr_en_d  = 1'b1;
          addr_d   = n_addr;
          colour_d = col_q;
        end
      end
      FILL: begin
        if (x_last && y_last) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          xc_d    = nx;
          yc_d    = ny;
          wr_en_d = 1'b1;
          addr_d  = n_addr;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      colour_q    <= '0;
      clr_q       <= 1'b0;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      xe_q        <= '0;
      ye_q        <= '0;
      xc_q        <= '0;
      yc_q        <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      colour_q    <= colour_d;
      clr_q       <= clr_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      col_q       <= col_d;
      xe_q        <= xe_d;
      ye_q        <= ye_d;
      xc_q        <= xc_d;
      yc_q        <= yc_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wr_en      = wr_en_q;
  assign wr_address = addr_q;
  assign wr_colour  = colour_q;

endmodule
